// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge
//
// Host-side debug front end. It receives a byte-serial command stream on
// UART_RX, turns each command into a single APB transfer on the 5-bit
// address / 8-bit data debug bus, and returns read data on UART_TX.
//
// Command byte: bit7 = write(1)/read(0), bits 6:5 ignored, bits 4:0 = PADDR.
// A write is the command byte followed by a data byte. A read is the command
// byte alone, and the bridge replies with one byte holding PRDATA.
//
// Ports:
//   PCLK     - clock, all state changes on the rising edge
//   PRESETn  - asynchronous active-low reset
//   UART_RX  - asynchronous serial input, 8N1, LSB first, idle high
//   UART_TX  - serial output, 8N1, LSB first, idle high
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA - APB master request signals
//   PRDATA, PREADY                       - APB slave response signals
//   BUSY     - high whenever the bridge FSM is not in IDLE
module uart_apb_bridge #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic       PSEL,
    output logic [4:0] PADDR,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    output logic       BUSY
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        SETUP,
        ACCESS,
        SEND
    } state_t;

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_byte;
    logic             rx_valid;

    state_t           state;
    state_t           state_next;

    logic [4:0]       paddr_q;
    logic             pwrite_q;
    logic [7:0]       pwdata_q;
    logic [7:0]       rdata_q;

    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [9:0]       tx_frame;
    logic             send_done;

    // Two-flop synchronizer; both flops reset high so reset never looks
    // like a start bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
        end
    end

    // UART receiver. The start bit is re-checked at its centre so short
    // glitches are rejected, then every later bit is sampled one full bit
    // period apart, which keeps each sample near the centre of its bit.
    // The receiver returns to idle right after sampling the stop bit so a
    // back-to-back start edge is seen half a bit later.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt  <= '0;
                    rx_bits <= '0;
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bits <= rx_bits + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_sync;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Bridge FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bridge FSM next-state logic. Bytes arriving outside IDLE/GET_DATA
    // are simply not looked at, which is what drops them.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_next = rx_byte[7] ? GET_DATA : SETUP;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_next = pwrite_q ? IDLE : SEND;
                end
            end
            SEND: begin
                if (send_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bridge FSM outputs. These decode the state register directly, so an
    // asynchronous reset drops PSEL/PENABLE/BUSY without waiting for PCLK.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        BUSY    = (state != IDLE);
        UART_TX = 1'b1;
        case (state)
            SETUP: PSEL = 1'b1;
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            SEND: UART_TX = tx_frame[tx_bit];
            default: ;
        endcase
    end

    // APB request and read-data holding registers. They only change while
    // no transfer is on the bus, so they are stable through SETUP/ACCESS.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && rx_valid) begin
                paddr_q  <= rx_byte[4:0];
                pwrite_q <= rx_byte[7];
            end
            if (state == GET_DATA && rx_valid) begin
                pwdata_q <= rx_byte;
            end
            if (state == ACCESS && PREADY && !pwrite_q) begin
                rdata_q <= PRDATA;
            end
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;

    // Transmit bit timing. Counters sit at zero outside SEND so the start
    // bit is driven in the very first SEND cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (state != SEND) begin
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx_frame  = {1'b1, rdata_q, 1'b0};
    assign send_done = (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);

endmodule

// File: tb/tb_uart_apb_bridge.sv
module tb_uart_apb_bridge;

    localparam int CPB = 16;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        int         waits;
    } apb_exp_t;

    logic       PCLK;
    logic       PRESETn;
    logic       UART_RX;
    logic       UART_TX;
    logic       PSEL;
    logic [4:0] PADDR;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       BUSY;

    int check_count = 0;
    int error_count = 0;

    apb_exp_t   apb_q[$];
    logic [7:0] reply_q[$];

    int         wait_cycles = 0;
    logic [7:0] read_value  = 8'h00;

    uart_apb_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .BUSY    (BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one 8N1 frame on UART_RX; the line is left idle high afterwards.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = frame[i];
            repeat (CPB) @(negedge PCLK);
        end
        UART_RX = 1'b1;
    endtask

    task automatic expectApb(input logic wr, input logic [4:0] addr,
                             input logic [7:0] data, input int waits);
        apb_exp_t e;
        e.wr    = wr;
        e.addr  = addr;
        e.data  = data;
        e.waits = waits;
        apb_q.push_back(e);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((apb_q.size() != 0 || reply_q.size() != 0 || BUSY !== 1'b0) && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("settle_within_budget", 32'(n < budget), 32'd1);
    endtask

    // APB slave model: PREADY is held low for wait_cycles ACCESS cycles,
    // and PRDATA carries junk until the completing cycle.
    initial begin
        int acc;
        acc    = 0;
        PREADY = 1'b1;
        PRDATA = 8'hEE;
        forever begin
            @(posedge PCLK);
            #1;
            if (PRESETn && PSEL && PENABLE) begin
                acc++;
                PREADY = (acc > wait_cycles);
            end else begin
                acc    = 0;
                PREADY = (wait_cycles == 0);
            end
            PRDATA = PREADY ? read_value : 8'hEE;
        end
    end

    // APB monitor: pops the expected transfer when one completes.
    initial begin
        int         psel_cyc;
        int         pen_cyc;
        int         stab_err;
        logic       gap_pending;
        logic [4:0] first_addr;
        logic       first_wr;
        logic [7:0] first_data;
        apb_exp_t   e;
        psel_cyc    = 0;
        pen_cyc     = 0;
        stab_err    = 0;
        gap_pending = 1'b0;
        first_addr  = '0;
        first_wr    = 1'b0;
        first_data  = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                psel_cyc    = 0;
                pen_cyc     = 0;
                stab_err    = 0;
                gap_pending = 1'b0;
            end else begin
                if (gap_pending) begin
                    checkOutput("penable_gap", 32'(PENABLE), 32'd0);
                    gap_pending = 1'b0;
                end
                if (PSEL) begin
                    if (psel_cyc == 0) begin
                        first_addr = PADDR;
                        first_wr   = PWRITE;
                        first_data = PWDATA;
                    end else if (PADDR !== first_addr || PWRITE !== first_wr ||
                                 PWDATA !== first_data) begin
                        stab_err++;
                    end
                    psel_cyc++;
                end
                if (PENABLE) pen_cyc++;
                if (PSEL && PENABLE && PREADY) begin
                    checkOutput("apb_transfer_expected", 32'(apb_q.size() != 0), 32'd1);
                    if (apb_q.size() != 0) begin
                        e = apb_q.pop_front();
                        checkOutput("apb_pwrite", 32'(PWRITE), 32'(e.wr));
                        checkOutput("apb_paddr", 32'(PADDR), 32'(e.addr));
                        if (e.wr) checkOutput("apb_pwdata", 32'(PWDATA), 32'(e.data));
                        checkOutput("apb_psel_cycles", 32'(psel_cyc), 32'(e.waits + 2));
                        checkOutput("apb_penable_cycles", 32'(pen_cyc), 32'(e.waits + 1));
                        checkOutput("apb_stable", 32'(stab_err), 32'd0);
                    end
                    psel_cyc    = 0;
                    pen_cyc     = 0;
                    stab_err    = 0;
                    gap_pending = 1'b1;
                end
            end
        end
    end

    // UART TX monitor: compares every cycle of a reply frame against the
    // ideal waveform of the expected byte, and decodes mid-bit samples.
    initial begin
        logic [7:0] exp_b;
        logic [7:0] got;
        logic [9:0] frame;
        int         shape_err;
        forever begin
            @(negedge PCLK);
            if (PRESETn && UART_TX === 1'b0) begin
                checkOutput("tx_frame_expected", 32'(reply_q.size() != 0), 32'd1);
                exp_b     = (reply_q.size() != 0) ? reply_q.pop_front() : 8'h00;
                frame     = {1'b1, exp_b, 1'b0};
                got       = '0;
                shape_err = 0;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) @(negedge PCLK);
                    if (UART_TX !== frame[i / CPB]) shape_err++;
                    if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8)
                        got[(i / CPB) - 1] = UART_TX;
                    if (i == 10 * CPB - 1) checkOutput("busy_in_stop_bit", 32'(BUSY), 32'd1);
                end
                checkOutput("tx_byte", 32'(got), 32'(exp_b));
                checkOutput("tx_bit_timing", 32'(shape_err), 32'd0);
                @(negedge PCLK);
                checkOutput("busy_after_tx", 32'(BUSY), 32'd0);
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", error_count);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        PRESETn = 1'b0;
        UART_RX = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        checkOutput("reset_uart_tx", 32'(UART_TX), 32'd1);
        checkOutput("reset_psel", 32'(PSEL), 32'd0);
        checkOutput("reset_penable", 32'(PENABLE), 32'd0);
        checkOutput("reset_pwrite", 32'(PWRITE), 32'd0);
        checkOutput("reset_paddr", 32'(PADDR), 32'd0);
        checkOutput("reset_pwdata", 32'(PWDATA), 32'd0);
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);

        $display("[TB] write 0x80, 0x01");
        wait_cycles = 0;
        expectApb(1'b1, 5'd0, 8'h01, 0);
        applyStimulus(8'h80, 1'b1);
        applyStimulus(8'h01, 1'b1);
        waitIdle(200);

        $display("[TB] read 0x03");
        read_value = 8'h0B;
        expectApb(1'b0, 5'd3, 8'h00, 0);
        reply_q.push_back(8'h0B);
        applyStimulus(8'h03, 1'b1);
        waitIdle(400);

        $display("[TB] read with 3 wait states");
        wait_cycles = 3;
        read_value  = 8'h5A;
        expectApb(1'b0, 5'd18, 8'h00, 3);
        reply_q.push_back(8'h5A);
        applyStimulus(8'h72, 1'b1);
        waitIdle(400);
        wait_cycles = 0;

        $display("[TB] framing error, glitch, then read of address 0");
        applyStimulus(8'h80, 1'b0);
        repeat (2 * CPB) @(negedge PCLK);
        UART_RX = 1'b0;
        repeat (5) @(negedge PCLK);
        UART_RX = 1'b1;
        repeat (3 * CPB) @(negedge PCLK);
        checkOutput("idle_after_rx_faults", 32'(BUSY), 32'd0);
        read_value = 8'h3C;
        expectApb(1'b0, 5'd0, 8'h00, 0);
        reply_q.push_back(8'h3C);
        applyStimulus(8'h00, 1'b1);
        waitIdle(400);

        $display("[TB] byte arriving during SEND is dropped");
        read_value = 8'hA5;
        expectApb(1'b0, 5'd0, 8'h00, 0);
        reply_q.push_back(8'hA5);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h81, 1'b1);
        waitIdle(400);
        repeat (3 * CPB) @(negedge PCLK);
        checkOutput("idle_after_drop", 32'(BUSY), 32'd0);

        $display("[TB] reset during ACCESS");
        wait_cycles = 1000;
        applyStimulus(8'h05, 1'b1);
        n = 0;
        while (PENABLE !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("reached_access", 32'(PENABLE), 32'd1);
        repeat (3) @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_psel", 32'(PSEL), 32'd0);
        checkOutput("async_reset_penable", 32'(PENABLE), 32'd0);
        checkOutput("async_reset_busy", 32'(BUSY), 32'd0);
        checkOutput("async_reset_uart_tx", 32'(UART_TX), 32'd1);
        wait_cycles = 0;
        @(negedge PCLK);
        #2;
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        expectApb(1'b1, 5'd4, 8'h04, 0);
        applyStimulus(8'h84, 1'b1);
        applyStimulus(8'h04, 1'b1);
        waitIdle(200);

        repeat (2 * CPB) @(negedge PCLK);
        checkOutput("apb_queue_drained", 32'(apb_q.size()), 32'd0);
        checkOutput("reply_queue_drained", 32'(reply_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
